// File: rtl/mips_hazard_unit.sv
// Hazard detection and forwarding control for the five-stage MIPS pipeline.
// Tracks in-flight destinations downstream of ID and drives stall/bubble/flush/forward selects.
module mips_hazard_unit #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned FWD_EN     = 1,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned FS_W       = $clog2(NUM_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_src1_used,
    input  logic                  id_src2_used,
    input  logic                  id_wb_en,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_mem_read,
    input  logic                  br_taken,
    output logic                  stall,
    output logic                  bubble,
    output logic                  flush_if,
    output logic [FS_W-1:0]       fwd_sel1,
    output logic [FS_W-1:0]       fwd_sel2,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    // Entry 1 is the instruction currently in EX; entry NUM_STAGES is at the MEM/WB output.
    logic [NUM_STAGES:1]   sb_valid_q;
    logic [NUM_STAGES:1]   sb_wb_q;
    logic [NUM_STAGES:1]   sb_load_q;
    logic [REG_ADDR_W-1:0] sb_dest_q [NUM_STAGES:1];

    logic [NUM_STAGES:1] match1;
    logic [NUM_STAGES:1] match2;
    logic [FS_W-1:0]     sel1;
    logic [FS_W-1:0]     sel2;
    logic                load_use;
    logic                hazard;

    always_comb begin
        match1 = '0;
        match2 = '0;
        sel1   = '0;
        sel2   = '0;
        for (int k = 1; k <= NUM_STAGES; k++) begin
            match1[k] = sb_valid_q[k] & sb_wb_q[k] & (sb_dest_q[k] == id_src1) & id_src1_used &
                        id_valid & (sb_dest_q[k] != '0);
            match2[k] = sb_valid_q[k] & sb_wb_q[k] & (sb_dest_q[k] == id_src2) & id_src2_used &
                        id_valid & (sb_dest_q[k] != '0);
        end
        // Walk oldest to youngest so the youngest match is written last.
        for (int k = NUM_STAGES; k >= 1; k--) begin
            if (match1[k]) sel1 = FS_W'(k);
            if (match2[k]) sel2 = FS_W'(k);
        end
        load_use = (match1[1] | match2[1]) & sb_load_q[1];
        if (FWD_EN != 0) begin
            hazard   = load_use;
            fwd_sel1 = sel1;
            fwd_sel2 = sel2;
        end else begin
            hazard   = (|match1) | (|match2);
            fwd_sel1 = '0;
            fwd_sel2 = '0;
        end
        flush_if = br_taken;
        stall    = hazard & ~br_taken;
        bubble   = hazard | br_taken;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_valid_q <= '0;
            sb_wb_q    <= '0;
            sb_load_q  <= '0;
            for (int k = 1; k <= NUM_STAGES; k++) sb_dest_q[k] <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            for (int k = NUM_STAGES; k >= 2; k--) begin
                sb_valid_q[k] <= sb_valid_q[k-1];
                sb_wb_q[k]    <= sb_wb_q[k-1];
                sb_load_q[k]  <= sb_load_q[k-1];
                sb_dest_q[k]  <= sb_dest_q[k-1];
            end
            sb_valid_q[1] <= id_valid & ~stall & ~br_taken;
            sb_wb_q[1]    <= id_wb_en;
            sb_load_q[1]  <= id_mem_read;
            sb_dest_q[1]  <= id_dest;
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (flush_if && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_hazard_unit.sv
// Self-checking bench: forwarding-mode and stall-only (CNT_W=2) instances share stimulus.
module tb_mips_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_src1_used, id_src2_used, id_wb_en, id_mem_read, br_taken;
    logic [4:0] id_src1, id_src2, id_dest;

    logic        st_f, bu_f, fl_f, st_s, bu_s, fl_s;
    logic [1:0]  f1_f, f2_f, f1_s, f2_s;
    logic [15:0] sc_f, fc_f;
    logic [1:0]  sc_s, fc_s;

    always #5 clk = ~clk;

    mips_hazard_unit #(.REG_ADDR_W(5), .NUM_STAGES(3), .FWD_EN(1), .CNT_W(16)) dut_f (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_used(id_src1_used), .id_src2_used(id_src2_used), .id_wb_en(id_wb_en),
        .id_dest(id_dest), .id_mem_read(id_mem_read), .br_taken(br_taken),
        .stall(st_f), .bubble(bu_f), .flush_if(fl_f), .fwd_sel1(f1_f), .fwd_sel2(f2_f),
        .stall_cnt(sc_f), .flush_cnt(fc_f)
    );

    mips_hazard_unit #(.REG_ADDR_W(5), .NUM_STAGES(3), .FWD_EN(0), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_used(id_src1_used), .id_src2_used(id_src2_used), .id_wb_en(id_wb_en),
        .id_dest(id_dest), .id_mem_read(id_mem_read), .br_taken(br_taken),
        .stall(st_s), .bubble(bu_s), .flush_if(fl_s), .fwd_sel1(f1_s), .fwd_sel2(f2_s),
        .stall_cnt(sc_s), .flush_cnt(fc_s)
    );

    typedef struct {
        bit       sel;          // 0 = forwarding instance, 1 = stall-only instance
        bit       v, u1, u2, wb, ld, br;
        bit [4:0] s1, s2, d;
        bit       e_st, e_bu, e_fl;
        bit       fcare;
        bit [1:0] e_f1, e_f2;
        int       e_sc, e_fc;   // -1 skips the counter check
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];
    int   nchecks = 0;
    int   nerrs   = 0;
    int   stepno  = 0;

    function automatic vec_t mk(bit sel, bit v, bit [4:0] s1, bit u1, bit [4:0] s2, bit u2,
                                bit wb, bit [4:0] d, bit ld, bit br, bit st, bit bu, bit fl,
                                bit fcare, bit [1:0] f1, bit [1:0] f2, int sc, int fc);
        vec_t t;
        t.sel = sel; t.v = v; t.s1 = s1; t.u1 = u1; t.s2 = s2; t.u2 = u2; t.wb = wb;
        t.d = d; t.ld = ld; t.br = br; t.e_st = st; t.e_bu = bu; t.e_fl = fl;
        t.fcare = fcare; t.e_f1 = f1; t.e_f2 = f2; t.e_sc = sc; t.e_fc = fc;
        return t;
    endfunction

    task automatic chk(string nm, int act, int exp);
        nchecks++;
        if (act != exp) begin
            nerrs++;
            $display("FAIL %s step %0d: got %0d expected %0d", nm, stepno, act, exp);
        end
    endtask

    // Drive one ID cycle, queue its expectation, compare on the falling edge.
    task automatic step(vec_t t);
        vec_t e;
        id_valid = t.v; id_src1 = t.s1; id_src1_used = t.u1; id_src2 = t.s2;
        id_src2_used = t.u2; id_wb_en = t.wb; id_dest = t.d; id_mem_read = t.ld;
        br_taken = t.br;
        sb_q.push_back(t);
        @(negedge clk);
        e = sb_q.pop_front();
        chk("stall",    e.sel ? int'(st_s) : int'(st_f), int'(e.e_st));
        chk("bubble",   e.sel ? int'(bu_s) : int'(bu_f), int'(e.e_bu));
        chk("flush_if", e.sel ? int'(fl_s) : int'(fl_f), int'(e.e_fl));
        if (e.fcare) begin
            chk("fwd_sel1", e.sel ? int'(f1_s) : int'(f1_f), int'(e.e_f1));
            chk("fwd_sel2", e.sel ? int'(f2_s) : int'(f2_f), int'(e.e_f2));
        end
        if (e.e_sc >= 0) chk("stall_cnt", e.sel ? int'(sc_s) : int'(sc_f), e.e_sc);
        if (e.e_fc >= 0) chk("flush_cnt", e.sel ? int'(fc_s) : int'(fc_f), e.e_fc);
        stepno++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t idle0, idle1;
        //           sel v s1 u1 s2 u2 wb d  ld br st bu fl fc f1 f2 sc  fcnt
        // Forwarding instance: distance tracking, youngest wins, load-use, flush, r0/unused.
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, -1, -1));
        vecs.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, -1, -1));
        vecs.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, -1, -1));
        vecs.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1, 0, 0, -1, -1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1, 0, 0, -1, -1));
        vecs.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, -1, -1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 1, 0, 0, -1, -1));
        vecs.push_back(mk(0, 1, 5, 1, 7, 1, 1, 6, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 5, 1, 7, 1, 1, 6, 0, 0, 0, 0, 0, 1, 2, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 8, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 8, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, -1, -1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, -1, -1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 1, 0, 0, -1, -1));
        vecs.push_back(mk(0, 1, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, -1, -1));
        vecs.push_back(mk(0, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, -1, -1));
        vecs.push_back(mk(0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1));

        idle0 = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle1 = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // Reset held two cycles with busy inputs, then everything must read back idle.
        rst = 1'b1;
        id_valid = 1; id_src1 = 3; id_src1_used = 1; id_src2 = 3; id_src2_used = 1;
        id_wb_en = 1; id_dest = 3; id_mem_read = 1; br_taken = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step(idle0);
        step(idle1);

        foreach (vecs[i]) step(vecs[i]);

        // Mid-operation reset must drop the in-flight producer and clear counters.
        step(mk(0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1, 0, 0, -1, -1));
        rst = 1'b1;
        id_valid = 0; br_taken = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        step(mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

        // Stall-only instance: 3 stalls from entry 1, then 2 more from entry 2; CNT_W=2 saturates.
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        step(mk(1, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        step(mk(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0));
        step(mk(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 1, 0));
        step(mk(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 2, 0));
        step(mk(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0));
        step(mk(1, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0));
        step(mk(1, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0));
        step(mk(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 3, 0));
        step(mk(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 3, 0));
        step(mk(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0));

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule
